// File: rtl/cpu_control_fsm.sv
// Moore control sequencer for the simple RISC CPU: fetch, PC update, decode, execute.
// Every output is a pure decode of the state register, so opcode/op cannot glitch them.
module cpu_control_fsm #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       load_addr,
    output logic       addr_sel,
    output logic [1:0] mem_cmd,
    output logic       halted
);

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b10;
    localparam logic [1:0] MWRITE = 2'b01;

    // opcode/op are only looked at in DEC, so each path through the shared
    // execute steps gets its own state to remember where it goes next.
    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPD, S_DEC, S_WIMM,
        S_GETA_ALU, S_GETA_CMP, S_GETA_LDR, S_GETA_STR,
        S_GETB_ALU, S_GETB_CMP, S_GETB_MOV,
        S_MOVC, S_ALU, S_CMP, S_WB,
        S_ADR_LDR, S_ADR_STR, S_LADR_LDR, S_LADR_STR,
        S_MRD, S_LWB, S_SGB, S_SMC, S_SWR, S_HALT
    } state_t;

    state_t state, state_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_RST;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RST:      state_nxt = S_IF1;
            S_IF1:      state_nxt = S_IF2;
            S_IF2:      state_nxt = S_UPD;
            S_UPD:      state_nxt = S_DEC;
            S_DEC: begin
                case ({opcode, op})
                    5'b110_10:            state_nxt = S_WIMM;
                    5'b110_00:            state_nxt = S_GETB_MOV;
                    5'b101_00, 5'b101_10: state_nxt = S_GETA_ALU;
                    5'b101_01:            state_nxt = S_GETA_CMP;
                    5'b101_11:            state_nxt = S_GETB_ALU;
                    5'b011_00:            state_nxt = S_GETA_LDR;
                    5'b100_00:            state_nxt = S_GETA_STR;
                    5'b111_00:            state_nxt = S_HALT;
                    default:              state_nxt = HALT_ON_ILLEGAL ? S_HALT : S_IF1;
                endcase
            end
            S_WIMM:     state_nxt = S_IF1;
            S_GETA_ALU: state_nxt = S_GETB_ALU;
            S_GETA_CMP: state_nxt = S_GETB_CMP;
            S_GETA_LDR: state_nxt = S_ADR_LDR;
            S_GETA_STR: state_nxt = S_ADR_STR;
            S_GETB_ALU: state_nxt = S_ALU;
            S_GETB_CMP: state_nxt = S_CMP;
            S_GETB_MOV: state_nxt = S_MOVC;
            S_MOVC:     state_nxt = S_WB;
            S_ALU:      state_nxt = S_WB;
            S_CMP:      state_nxt = S_IF1;
            S_WB:       state_nxt = S_IF1;
            S_ADR_LDR:  state_nxt = S_LADR_LDR;
            S_ADR_STR:  state_nxt = S_LADR_STR;
            S_LADR_LDR: state_nxt = S_MRD;
            S_LADR_STR: state_nxt = S_SGB;
            S_MRD:      state_nxt = S_LWB;
            S_LWB:      state_nxt = S_IF1;
            S_SGB:      state_nxt = S_SMC;
            S_SMC:      state_nxt = S_SWR;
            S_SWR:      state_nxt = S_IF1;
            S_HALT:     state_nxt = S_HALT;
            default:    state_nxt = S_RST;
        endcase
    end

    always_comb begin
        nsel      = 3'b000;
        vsel      = 2'b00;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        load_addr = 1'b0;
        addr_sel  = 1'b0;
        mem_cmd   = MNONE;
        halted    = 1'b0;
        case (state)
            S_RST: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
            end
            S_IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = MREAD;
            end
            S_IF2: begin
                addr_sel = 1'b1;
                mem_cmd  = MREAD;
                load_ir  = 1'b1;
            end
            S_UPD:  load_pc = 1'b1;
            S_WIMM: begin
                nsel  = 3'b001;
                vsel  = 2'b10;
                write = 1'b1;
            end
            S_GETA_ALU, S_GETA_CMP, S_GETA_LDR, S_GETA_STR: begin
                nsel  = 3'b101;
                loada = 1'b1;
            end
            S_GETB_ALU, S_GETB_CMP, S_GETB_MOV: begin
                nsel  = 3'b010;
                loadb = 1'b1;
            end
            S_MOVC, S_SMC: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            S_ALU:  loadc = 1'b1;
            S_CMP:  loads = 1'b1;
            S_WB: begin
                nsel  = 3'b100;
                vsel  = 2'b00;
                write = 1'b1;
            end
            S_ADR_LDR, S_ADR_STR: begin
                bsel  = 1'b1;
                loadc = 1'b1;
            end
            S_LADR_LDR, S_LADR_STR: load_addr = 1'b1;
            S_MRD:  mem_cmd = MREAD;
            S_LWB: begin
                mem_cmd = MREAD;
                nsel    = 3'b100;
                vsel    = 2'b11;
                write   = 1'b1;
            end
            // store data comes from Rd, so the decoder maps nsel 110 to readnum=Rd
            S_SGB: begin
                nsel  = 3'b110;
                loadb = 1'b1;
            end
            S_SWR:  mem_cmd = MWRITE;
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: per-cycle expected output table for each
// instruction class, plus hand sequences for reset, HALT and mid-instruction reset.
module tb_cpu_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write, loada, loadb, loadc, loads, asel, bsel;
    logic       load_ir, load_pc, reset_pc, load_addr, addr_sel, halted;
    logic [1:0] mem_cmd;

    int checks   = 0;
    int failures = 0;

    cpu_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op),
        .nsel(nsel), .vsel(vsel), .write(write), .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .load_ir(load_ir),
        .load_pc(load_pc), .reset_pc(reset_pc), .load_addr(load_addr),
        .addr_sel(addr_sel), .mem_cmd(mem_cmd), .halted(halted)
    );

    always #5 clk = ~clk;

    // {nsel[19:17], vsel[16:15], write, loada, loadb, loadc, loads, asel, bsel,
    //  load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_cmd[2:1], halted}
    logic [19:0] obs;
    assign obs = {nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
                  load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_cmd, halted};

    localparam logic [19:0] E_RST  = 20'h00060;
    localparam logic [19:0] E_IF1  = 20'h0000C;
    localparam logic [19:0] E_IF2  = 20'h0008C;
    localparam logic [19:0] E_UPD  = 20'h00040;
    localparam logic [19:0] E_DEC  = 20'h00000;
    localparam logic [19:0] E_WIMM = 20'h34000;
    localparam logic [19:0] E_GETA = 20'hA2000;
    localparam logic [19:0] E_GETB = 20'h41000;
    localparam logic [19:0] E_MOVC = 20'h00A00;
    localparam logic [19:0] E_ALU  = 20'h00800;
    localparam logic [19:0] E_CMP  = 20'h00400;
    localparam logic [19:0] E_WB   = 20'h84000;
    localparam logic [19:0] E_ADR  = 20'h00900;
    localparam logic [19:0] E_LADR = 20'h00010;
    localparam logic [19:0] E_MRD  = 20'h00004;
    localparam logic [19:0] E_LWB  = 20'h9C004;
    localparam logic [19:0] E_SGB  = 20'hC1000;
    localparam logic [19:0] E_SMC  = 20'h00A00;
    localparam logic [19:0] E_SWR  = 20'h00002;
    localparam logic [19:0] E_HALT = 20'h00001;

    typedef struct {
        logic [2:0]  opcode;
        logic [1:0]  op;
        logic [19:0] exp;
        string       tag;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [2:0] oc, input logic [1:0] o,
                       input logic [19:0] e, input string t);
        vec_t v;
        v.opcode = oc; v.op = o; v.exp = e; v.tag = t;
        tbl.push_back(v);
    endtask

    // every instruction starts from IF1; the fetch prologue is common
    task automatic add_fetch(input logic [2:0] oc, input logic [1:0] o, input string t);
        add(oc, o, E_IF1, {t, "_if1"});
        add(oc, o, E_IF2, {t, "_if2"});
        add(oc, o, E_UPD, {t, "_upd"});
        add(oc, o, E_DEC, {t, "_dec"});
    endtask

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %05h want %05h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", obs, E_RST);
        end
        reset = 1'b1;
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            @(negedge clk);
            opcode = tbl[i].opcode;
            op     = tbl[i].op;
            check(tbl[i].tag, obs, tbl[i].exp);
        end
        tbl.delete();
    endtask

    initial begin
        reset  = 1'b0;
        opcode = 3'b000;
        op     = 2'b00;
        #1;
        check("reset_async", obs, E_RST);

        do_reset();
        // MOV imm: 5 cycles
        add_fetch(3'b110, 2'b10, "movi");
        add(3'b110, 2'b10, E_WIMM, "movi_wimm");
        // ADD: 8 cycles
        add_fetch(3'b101, 2'b00, "add");
        add(3'b101, 2'b00, E_GETA, "add_geta");
        add(3'b101, 2'b00, E_GETB, "add_getb");
        add(3'b101, 2'b00, E_ALU,  "add_alu");
        add(3'b101, 2'b00, E_WB,   "add_wb");
        // CMP: 7 cycles, loads but no write
        add_fetch(3'b101, 2'b01, "cmp");
        add(3'b101, 2'b01, E_GETA, "cmp_geta");
        add(3'b101, 2'b01, E_GETB, "cmp_getb");
        add(3'b101, 2'b01, E_CMP,  "cmp_cmp");
        // AND: same shape as ADD
        add_fetch(3'b101, 2'b10, "and");
        add(3'b101, 2'b10, E_GETA, "and_geta");
        add(3'b101, 2'b10, E_GETB, "and_getb");
        add(3'b101, 2'b10, E_ALU,  "and_alu");
        add(3'b101, 2'b10, E_WB,   "and_wb");
        // MVN: 7 cycles
        add_fetch(3'b101, 2'b11, "mvn");
        add(3'b101, 2'b11, E_GETB, "mvn_getb");
        add(3'b101, 2'b11, E_ALU,  "mvn_alu");
        add(3'b101, 2'b11, E_WB,   "mvn_wb");
        // MOV reg: 7 cycles
        add_fetch(3'b110, 2'b00, "movr");
        add(3'b110, 2'b00, E_GETB, "movr_getb");
        add(3'b110, 2'b00, E_MOVC, "movr_movc");
        add(3'b110, 2'b00, E_WB,   "movr_wb");
        // LDR: 9 cycles
        add_fetch(3'b011, 2'b00, "ldr");
        add(3'b011, 2'b00, E_GETA, "ldr_geta");
        add(3'b011, 2'b00, E_ADR,  "ldr_adr");
        add(3'b011, 2'b00, E_LADR, "ldr_ladr");
        add(3'b011, 2'b00, E_MRD,  "ldr_mrd");
        add(3'b011, 2'b00, E_LWB,  "ldr_lwb");
        // STR: 10 cycles, SWR writes memory with write=0
        add_fetch(3'b100, 2'b00, "str");
        add(3'b100, 2'b00, E_GETA, "str_geta");
        add(3'b100, 2'b00, E_ADR,  "str_adr");
        add(3'b100, 2'b00, E_LADR, "str_ladr");
        add(3'b100, 2'b00, E_SGB,  "str_sgb");
        add(3'b100, 2'b00, E_SMC,  "str_smc");
        add(3'b100, 2'b00, E_SWR,  "str_swr");
        // HALT entry; lands back in IF1 first, proving STR length
        add_fetch(3'b111, 2'b00, "halt");
        run_table();

        // HALT absorbs for 20 clocks whatever opcode/op do
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            opcode = 3'($urandom_range(0, 7));
            op     = 2'($urandom_range(0, 3));
            check("halt_hold", obs, E_HALT);
        end

        // illegal opcode/op halts with the default parameter
        do_reset();
        add_fetch(3'b110, 2'b01, "ill");
        add(3'b110, 2'b01, E_HALT, "ill_halt");
        add(3'b010, 2'b00, E_HALT, "ill_stay");
        run_table();

        // reset asserted during GETB of an ADD: immediate RST, WB never happens
        do_reset();
        add_fetch(3'b101, 2'b00, "arst");
        add(3'b101, 2'b00, E_GETA, "arst_geta");
        add(3'b101, 2'b00, E_GETB, "arst_getb");
        run_table();
        reset = 1'b0;
        #1;
        check("arst_immediate", obs, E_RST);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("arst_nowrite", {19'd0, write}, 20'd0);
            check("arst_hold", obs, E_RST);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("arst_release_if1", obs, E_IF1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
